// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch-request controller for a single-ported instruction memory.
// Holds each request stable until accepted and defers stall/halt/redirect to the next accept.
module pc_fetch_ctrl #(
   parameter int          AWIDTH     = 6,
   parameter int unsigned RESET_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              stall,
   input  logic              redirect,
   input  logic [AWIDTH-1:0] redirect_addr,
   input  logic              halt,
   input  logic              imem_ready,
   output logic              imem_req,
   output logic [AWIDTH-1:0] imem_addr,
   output logic [AWIDTH-1:0] pc,
   output logic              fetch_done,
   output logic [AWIDTH-1:0] fetch_addr,
   output logic              wrap,
   output logic              halted,
   output logic [7:0]        fetch_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      STALL = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t            state, state_nx;
   logic [AWIDTH-1:0] pc_nx;
   logic              pend_redir, pend_redir_nx;
   logic [AWIDTH-1:0] pend_addr, pend_addr_nx;
   logic              pend_halt, pend_halt_nx;
   logic              pend_stall, pend_stall_nx;
   logic              fetch_done_nx;
   logic [AWIDTH-1:0] fetch_addr_nx;
   logic              wrap_nx;
   logic [7:0]        fetch_count_nx;

   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;
   assign halted    = (state == HALT);

   always_comb begin
      // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
      state_nx       = state;
      pc_nx          = pc;
      pend_redir_nx  = pend_redir;
      pend_addr_nx   = pend_addr;
      pend_halt_nx   = pend_halt;
      pend_stall_nx  = pend_stall;
      fetch_done_nx  = 1'b0;
      fetch_addr_nx  = fetch_addr;
      wrap_nx        = 1'b0;
      fetch_count_nx = fetch_count;

      unique case (state)
         IDLE: begin
            if (halt)
               state_nx = HALT;
            else if (run)
               state_nx = FETCH;
         end

         FETCH: begin
            if (imem_ready) begin
               fetch_done_nx = 1'b1;
               fetch_addr_nx = pc;
               if (fetch_count != 8'hFF)
                  fetch_count_nx = fetch_count + 8'd1;

               // A redirect arriving on the accept cycle is newer than any pending one.
               if (redirect)
                  pc_nx = redirect_addr;
               else if (pend_redir)
                  pc_nx = pend_addr;
               else begin
                  pc_nx   = pc + 1'b1;
                  wrap_nx = (pc == '1);
               end

               pend_redir_nx = 1'b0;
               pend_halt_nx  = 1'b0;
               pend_stall_nx = 1'b0;

               if (halt || pend_halt)
                  state_nx = HALT;
               else if (stall || pend_stall)
                  state_nx = STALL;
            end else begin
               if (redirect) begin
                  pend_redir_nx = 1'b1;
                  pend_addr_nx  = redirect_addr;
               end
               if (halt)
                  pend_halt_nx = 1'b1;
               if (stall)
                  pend_stall_nx = 1'b1;
            end
         end

         STALL: begin
            if (halt)
               state_nx = HALT;
            else begin
               if (redirect)
                  pc_nx = redirect_addr;
               if (!stall)
                  state_nx = FETCH;
            end
         end

         HALT: ;

         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= AWIDTH'(RESET_ADDR);
         pend_redir  <= 1'b0;
         pend_addr   <= '0;
         pend_halt   <= 1'b0;
         pend_stall  <= 1'b0;
         fetch_done  <= 1'b0;
         fetch_addr  <= '0;
         wrap        <= 1'b0;
         fetch_count <= 8'd0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         pend_redir  <= pend_redir_nx;
         pend_addr   <= pend_addr_nx;
         pend_halt   <= pend_halt_nx;
         pend_stall  <= pend_stall_nx;
         fetch_done  <= fetch_done_nx;
         fetch_addr  <= fetch_addr_nx;
         wrap        <= wrap_nx;
         fetch_count <= fetch_count_nx;
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: reset, streaming, wrap, redirect hold, stall, halt,
// reset mid-request and fetch-count saturation, each with hand-computed expectations.
module tb_pc_fetch_ctrl;

   localparam int AWIDTH = 6;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              run;
   logic              stall;
   logic              redirect;
   logic [AWIDTH-1:0] redirect_addr;
   logic              halt;
   logic              imem_ready;
   logic              imem_req;
   logic [AWIDTH-1:0] imem_addr;
   logic [AWIDTH-1:0] pc;
   logic              fetch_done;
   logic [AWIDTH-1:0] fetch_addr;
   logic              wrap;
   logic              halted;
   logic [7:0]        fetch_count;

   int total = 0;
   int bad   = 0;

   pc_fetch_ctrl #(.AWIDTH(AWIDTH), .RESET_ADDR(0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .run           (run),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .halt          (halt),
      .imem_ready    (imem_ready),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .pc            (pc),
      .fetch_done    (fetch_done),
      .fetch_addr    (fetch_addr),
      .wrap          (wrap),
      .halted        (halted),
      .fetch_count   (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One rising edge, then settle so registered outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int guard;

      rst_n = 1'b0; run = 1'b0; stall = 1'b0; redirect = 1'b0;
      redirect_addr = '0; halt = 1'b0; imem_ready = 1'b0;
      step(); step();
      check("rst_req",   imem_req,    0);
      check("rst_pc",    pc,          0);
      check("rst_done",  fetch_done,  0);
      check("rst_wrap",  wrap,        0);
      check("rst_halt",  halted,      0);
      check("rst_faddr", fetch_addr,  0);
      check("rst_cnt",   fetch_count, 0);

      // Streaming with imem_ready always high
      rst_n = 1'b1; run = 1'b1; imem_ready = 1'b1;
      step();
      check("s_req",   imem_req,   1);
      check("s_addr0", imem_addr,  0);
      check("s_done0", fetch_done, 0);
      for (int i = 1; i <= 3; i++) begin
         step();
         check($sformatf("s_addr%0d", i),  imem_addr,  i);
         check($sformatf("s_done%0d", i),  fetch_done, 1);
         check($sformatf("s_faddr%0d", i), fetch_addr, i - 1);
      end

      // Run up to pc=63, then wrap
      guard = 0;
      while (pc != 6'd63 && guard < 100) begin
         step();
         guard++;
      end
      check("w_reach63", pc, 63);
      step();
      check("w_pc0",   pc,         0);
      check("w_wrap",  wrap,       1);
      check("w_faddr", fetch_addr, 63);
      step();
      check("w_wrap_1cyc", wrap,       0);
      check("w_pc1",       pc,         1);
      check("w_cnt65",     fetch_count, 65);

      // Request held while not ready; redirect in cycle 2 is pended
      imem_ready = 1'b0;
      step();
      check("r_hold1", imem_addr,  1);
      check("r_req1",  imem_req,   1);
      check("r_done1", fetch_done, 0);
      redirect = 1'b1; redirect_addr = 6'h20;
      step();
      check("r_hold2", imem_addr, 1);
      redirect = 1'b0; redirect_addr = 6'h00;
      step();
      check("r_hold3", imem_addr, 1);
      imem_ready = 1'b1;
      step();
      check("r_pc",    pc,         6'h20);
      check("r_faddr", fetch_addr, 1);
      check("r_done",  fetch_done, 1);
      check("r_nowrap", wrap,      0);

      // Redirect on the accept cycle itself, to pc=5
      redirect = 1'b1; redirect_addr = 6'd5;
      step();
      redirect = 1'b0; redirect_addr = 6'd0;
      check("d_pc5", pc, 5);

      // Stall raised at the accept of pc=5
      stall = 1'b1;
      step();
      check("t_req0",  imem_req,   0);
      check("t_pc6",   pc,         6);
      check("t_faddr", fetch_addr, 5);
      step();
      check("t_req_held", imem_req,   0);
      check("t_pc_held",  pc,         6);
      check("t_nodone",   fetch_done, 0);
      stall = 1'b0;
      step();
      check("t_resume_req",  imem_req,  1);
      check("t_resume_addr", imem_addr, 6);
      step();
      check("t_pc7", pc, 7);
      check("t_cnt", fetch_count, 69);

      // Halt while not ready: finish the request, then HALT
      imem_ready = 1'b0; halt = 1'b1;
      step();
      check("h_req_kept", imem_req, 1);
      check("h_not_yet",  halted,   0);
      halt = 1'b0;
      step();
      check("h_req_kept2", imem_req, 1);
      imem_ready = 1'b1;
      step();
      check("h_halted", halted,     1);
      check("h_req0",   imem_req,   0);
      check("h_pc8",    pc,         8);
      check("h_faddr",  fetch_addr, 7);
      run = 1'b1; redirect = 1'b1; redirect_addr = 6'd3;
      step(); step(); step();
      redirect = 1'b0;
      check("h_stay",    halted,      1);
      check("h_req_off", imem_req,    0);
      check("h_pc_kept", pc,          8);
      check("h_cnt",     fetch_count, 70);

      // Reset in the middle of an outstanding request
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; run = 1'b1; imem_ready = 1'b0;
      step();
      check("x_req", imem_req, 1);
      step();
      rst_n = 1'b0;
      step();
      check("x_req0", imem_req,    0);
      check("x_pc0",  pc,          0);
      check("x_cnt0", fetch_count, 0);
      check("x_halt", halted,      0);
      rst_n = 1'b1; imem_ready = 1'b1;
      step();
      check("x_nodone", fetch_done, 0);

      // Saturating fetch count
      for (int i = 1; i <= 300; i++) begin
         step();
         if (i == 254) check("c_254", fetch_count, 254);
         if (i == 255) check("c_255", fetch_count, 255);
      end
      check("c_sat", fetch_count, 255);

      // Redirect to 0 never raises wrap
      redirect = 1'b1; redirect_addr = 6'd0;
      step();
      redirect = 1'b0;
      check("z_pc0",   pc,   0);
      check("z_nowrap", wrap, 0);

      // Halt has priority over run in IDLE
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; run = 1'b1; halt = 1'b1;
      step();
      halt = 1'b0;
      check("i_halt", halted,   1);
      check("i_req0", imem_req, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
